kypd_scan: RTL

Scanner and debouncer for a 4x4 matrix keypad on a PMOD header; the input-side counterpart to the LED display blocks. Drives one column low at a time, samples the four active-low row lines, and debounces whole scan frames. Reports each debounced press as a single-cycle `key_valid` pulse carrying a 4-bit hex key code. Downstream logic, such as an LED press counter, consumes `key`/`key_valid` directly.

---
 rtl/kypd_pkg.sv | 28 ++
 rtl/sync2.sv | 24 ++
 rtl/kypd_scan.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/kypd_pkg.sv
// rtl/kypd_pkg.sv - shared types and constants for the 4x4 keypad scanner
// Contents: debounce state enum, row/column counts, and the key-map lookup
// indexed by {column, row}.
package kypd_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } deb_state_t;

  // Nibble {c,r} holds the key code for row r, column c.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,   // col3, rows 3..0
    4'hE, 4'h9, 4'h6, 4'h3,   // col2
    4'hF, 4'h8, 4'h5, 4'h2,   // col1
    4'h0, 4'h7, 4'h4, 4'h1    // col0
  };

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic N-bit two-flop synchroniser
// Ports: clk, rst (async, active-high), d (asynchronous input), q (synchronised).
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/kypd_scan.sv
// rtl/kypd_scan.sv - 4x4 matrix keypad scanner with frame debouncer
// Ports: clk, rst (async, active-high), row (active-low, async),
// col (one-cold drive), key (last accepted code), key_valid (accept pulse),
// key_down (high from accept until release is debounced).
module kypd_scan
  import kypd_pkg::*;
#(
  parameter int SCAN_CYCLES     = 12000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key,
  output logic                key_valid,
  output logic                key_down
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [NUM_ROWS-1:0] row_s;

  sync2 #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_s)
  );

  // Scanner: dwell on each column, sample rows on the last dwell cycle.
  logic [DW-1:0] dwell;
  logic [1:0]    c;
  logic [15:0]   frame;
  logic          frame_rdy;
  logic          sample;

  assign sample = (dwell == DWELL_LAST);
  assign col    = ~(4'b0001 << c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell     <= '0;
      c         <= '0;
      frame     <= '0;
      frame_rdy <= 1'b0;
    end else begin
      // frame_rdy marks the evaluation cycle right after the column-3 sample;
      // the next column-0 sample is at least 3 cycles away, so clearing here
      // never collides with a sample write.
      frame_rdy <= sample && (c == 2'd3);
      if (frame_rdy)
        frame <= '0;
      if (sample) begin
        dwell                  <= '0;
        c                      <= c + 2'd1;
        frame[{c, 2'b00} +: 4] <= ~row_s;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Classifier: bit index {c,r} of a lone set bit is directly the key-map index.
  logic [4:0] n_set;
  logic [3:0] hit;
  logic       f_empty;
  logic       f_single;
  logic [3:0] k;

  always_comb begin
    n_set = '0;
    hit   = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        n_set = n_set + 5'd1;
        hit   = 4'(i);
      end
    end
  end

  assign f_empty  = (n_set == 5'd0);
  assign f_single = (n_set == 5'd1);
  assign k        = key_code(hit);

  // Debounce FSM.
  deb_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    cand, cand_n;
  logic          accept, rel_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RELEASED;
      cnt       <= '0;
      cand      <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_valid <= accept;
      if (accept) begin
        key      <= cand_n;
        key_down <= 1'b1;
      end else if (rel_done) begin
        key_down <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cand_n   = cand;
    accept   = 1'b0;
    rel_done = 1'b0;
    if (frame_rdy) begin
      unique case (state)
        RELEASED: begin
          if (f_single) begin
            cand_n = k;
            cnt_n  = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end else begin
              state_n = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (f_single && (k == cand)) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CNT_LAST) begin
              accept  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end
          end else if (f_single) begin
            cand_n = k;
            cnt_n  = CNT_ONE;
          end else begin
            cnt_n   = '0;
            state_n = RELEASED;
          end
        end
        HELD: begin
          // Roll-over and extra keys are deliberately ignored here.
          if (f_empty) begin
            cnt_n = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              rel_done = 1'b1;
              cnt_n    = '0;
              state_n  = RELEASED;
            end else begin
              state_n = RELEASE_DEB;
            end
          end
        end
        RELEASE_DEB: begin
          if (f_empty) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CNT_LAST) begin
              rel_done = 1'b1;
              cnt_n    = '0;
              state_n  = RELEASED;
            end
          end else begin
            cnt_n   = '0;
            state_n = HELD;
          end
        end
        default: state_n = RELEASED;
      endcase
    end
  end

endmodule
